mandelbrot_iter_unit: RTL and testbench
=======================================

# mandelbrot_iter_unit

Sequential Mandelbrot/Julia escape-time engine. It accepts one point per request, runs one z = z² + c update per clock, and stops on the first of three conditions: magnitude escape, fixed-point overflow, or the iteration limit. It returns the iteration count, the escape reason and the final z. It sits between the pixel scanner, which issues points, and the colour mapper, which consumes results. It generalises the single-step combinational ALU with a programmable limit, a start/done handshake and an optional Julia mode.

## Interface
- WIDTH, 8, data width of c and z. Signed fixed point Q2.(WIDTH-2), range [-2, 2).
- CTR_WIDTH, 7, width of the iteration counter and of max_iter.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only in IDLE.
- in_cr, in_ci  in  WIDTH  c, signed.
- in_zr0, in_zi0  in  WIDTH  initial z, Julia mode only.
- in_julia  in  1  1 = Julia mode, z0 = in_z*0; 0 = Mandelbrot mode, z0 = 0.
- in_max_iter  in  CTR_WIDTH  iteration limit, unsigned.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle result-valid pulse.
- out_iter  out  CTR_WIDTH  number of committed updates.
- out_escaped  out  1  point escaped.
- out_ovf  out  1  escape was caused by overflow, not by magnitude.
- out_zr, out_zi  out  WIDTH  last committed z.

## Operation
- FSM states: IDLE, RUN.
- IDLE + start: latch c, max_iter, z0 and mode; clear iter; go to RUN. Inputs are ignored after latching.
- Each RUN cycle evaluates the following, in priority order:
  1. iter == max_iter: finish with escaped=0.
  2. |z|² > 4.0: finish with escaped=1, ovf=0.
  3. New z outside the WIDTH range: finish with escaped=1, ovf=1. The new z is not committed.
  4. Otherwise commit the new z, iter += 1, stay in RUN.
- Finish: register the results, pulse done, go to IDLE.
- Arithmetic:
  - m1 = zr², m2 = zi², m3 = zr·zi, each full 2·WIDTH precision. Internal sums are 2·WIDTH+2 bits, so they cannot wrap.
  - Magnitude check: unsigned (m1 + m2) > (4 << (2·WIDTH-4)). Exactly 4.0 does not escape.
  - new_zr = ((m1 − m2) >>> (WIDTH-2)) + cr.
  - new_zi = ((m3 << 1) >>> (WIDTH-2)) + ci.
  - Shifts are arithmetic: truncation toward −∞, no rounding.
  - Overflow: the full-width result is outside [−2^(WIDTH-1), 2^(WIDTH-1)−1]. Never saturate, never wrap.
- in_max_iter = 0: finish on the first RUN cycle with iter=0 and escaped=0. No magnitude or overflow check is made.
- start while busy: ignored; no queuing.
- Result outputs hold their values until the next finish or reset.

## Timing
- Reset: state IDLE; busy, done, out_iter, out_escaped, out_ovf, out_zr and out_zi all 0.
- Reset in RUN aborts the request with no done pulse. It wins over a simultaneous start or finish.
- Latency, with start sampled at edge e0 and result iteration count k:
  - busy is high from e0 to e(k+1).
  - done is high for exactly the one cycle after e(k+1); busy is low in that cycle.
- Throughput: the unit accepts start in the same cycle done is high, so results can be back-to-back with no idle cycle.
- Data paths are fully combinational within one cycle; there are no pipeline stages in the loop.

## Configuration
- MANDELBROT_JULIA_EN defined: in_julia, in_zr0 and in_zi0 behave as described above.
- MANDELBROT_JULIA_EN undefined:
  - The ports remain and are ignored.
  - z0 is always 0; the mode flop and z0 latch are not built.
  - Mandelbrot behaviour is bit-identical to the enabled build with in_julia=0.

## Test plan
All cases use WIDTH=8, CTR_WIDTH=7, Mandelbrot mode unless stated.
- c=0, max_iter=10 -> done 11 cycles after start; iter=10, escaped=0, z=0.
- c=1.0 (0x40, 0x00), max_iter=50 -> escaped=1, ovf=1, iter=1, out_zr=0x40; done 2 cycles after start.
- c=1.5+1.5i (0x60, 0x60) -> escaped=1, ovf=0, iter=1, z=(0x60, 0x60).
- c=−1.0 (0xC0), max_iter=20 -> escaped=0, iter=20, z=0.
  - A start pulse mid-run is ignored.
  - A start in the done cycle is accepted; check the back-to-back timing.
- Julia, z0=1.5 (0x60), c=0, max_iter=5 -> escaped=1, ovf=1, iter=0.
  - Without MANDELBROT_JULIA_EN, the same stimulus gives iter=5, escaped=0.
- rst pulsed on the 3rd RUN cycle of case 1 -> no done pulse; all outputs 0 the next cycle; a new start then runs normally.

Source files
------------

// File: rtl/mandelbrot_iter_unit_if.sv
//==============================================================================
// Module      : mandelbrot_iter_unit_if
// Description : Request/result bundle between the pixel scanner (master) and
//               the Mandelbrot/Julia escape-time engine (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mandelbrot_iter_unit_if #(
  parameter int WIDTH     = 8,
  parameter int CTR_WIDTH = 7
);
  logic                 start;
  logic [WIDTH-1:0]     in_cr;
  logic [WIDTH-1:0]     in_ci;
  logic [WIDTH-1:0]     in_zr0;
  logic [WIDTH-1:0]     in_zi0;
  logic                 in_julia;
  logic [CTR_WIDTH-1:0] in_max_iter;
  logic                 busy;
  logic                 done;
  logic [CTR_WIDTH-1:0] out_iter;
  logic                 out_escaped;
  logic                 out_ovf;
  logic [WIDTH-1:0]     out_zr;
  logic [WIDTH-1:0]     out_zi;

  modport master (
    output start, in_cr, in_ci, in_zr0, in_zi0, in_julia, in_max_iter,
    input  busy, done, out_iter, out_escaped, out_ovf, out_zr, out_zi
  );

  modport slave (
    input  start, in_cr, in_ci, in_zr0, in_zi0, in_julia, in_max_iter,
    output busy, done, out_iter, out_escaped, out_ovf, out_zr, out_zi
  );
endinterface

`default_nettype wire

// File: rtl/mandelbrot_iter_unit.sv
//==============================================================================
// Module      : mandelbrot_iter_unit
// Description : Sequential escape-time engine, one z = z^2 + c update per
//               clock. Stops on iteration limit, |z|^2 > 4 or Q2.x overflow.
//               Optional Julia mode (z0 from inputs) when MANDELBROT_JULIA_EN
//               is defined; otherwise z0 is always zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mandelbrot_iter_unit #(
  parameter int WIDTH     = 8,
  parameter int CTR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  mandelbrot_iter_unit_if.slave bus
);

  // Internal arithmetic is wide enough that no intermediate can wrap.
  localparam int SW = 2 * WIDTH + 2;
  localparam logic signed [SW-1:0] C_MAG_LIM = SW'(4) <<< (2 * WIDTH - 4);
  localparam logic signed [SW-1:0] C_ZMAX    = SW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] C_ZMIN    = -C_ZMAX - SW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [WIDTH-1:0] r_zr, r_zi, r_cr, r_ci;
  logic [CTR_WIDTH-1:0]    r_iter, r_max;
  logic [WIDTH-1:0]        w_zr0, w_zi0;

  logic                    r_done, r_escaped, r_ovf;
  logic [CTR_WIDTH-1:0]    r_out_iter;
  logic [WIDTH-1:0]        r_out_zr, r_out_zi;

  logic w_accept, w_commit, w_finish, w_esc_nxt, w_ovf_nxt;

`ifdef MANDELBROT_JULIA_EN
  assign w_zr0 = bus.in_julia ? bus.in_zr0 : '0;
  assign w_zi0 = bus.in_julia ? bus.in_zi0 : '0;
`else
  // Julia ports stay on the interface but have no effect in this build.
  logic w_unused_julia;
  assign w_unused_julia = ^{bus.in_julia, bus.in_zr0, bus.in_zi0};
  assign w_zr0 = '0;
  assign w_zi0 = '0;
`endif

  // Sign-extended operands, full-precision products and the next z.
  logic signed [SW-1:0] w_zr_x, w_zi_x, w_cr_x, w_ci_x;
  logic signed [SW-1:0] w_m1, w_m2, w_m3, w_mag, w_nzr, w_nzi;
  logic                 w_mag_esc, w_range_ovf;

  assign w_zr_x = {{(SW-WIDTH){r_zr[WIDTH-1]}}, r_zr};
  assign w_zi_x = {{(SW-WIDTH){r_zi[WIDTH-1]}}, r_zi};
  assign w_cr_x = {{(SW-WIDTH){r_cr[WIDTH-1]}}, r_cr};
  assign w_ci_x = {{(SW-WIDTH){r_ci[WIDTH-1]}}, r_ci};

  assign w_m1  = w_zr_x * w_zr_x;
  assign w_m2  = w_zi_x * w_zi_x;
  assign w_m3  = w_zr_x * w_zi_x;
  assign w_mag = w_m1 + w_m2;
  // Arithmetic shifts floor toward -inf; no rounding is applied.
  assign w_nzr = ((w_m1 - w_m2) >>> (WIDTH - 2)) + w_cr_x;
  assign w_nzi = ((w_m3 <<< 1) >>> (WIDTH - 2)) + w_ci_x;

  assign w_mag_esc   = (w_mag > C_MAG_LIM);
  assign w_range_ovf = (w_nzr > C_ZMAX) || (w_nzr < C_ZMIN) ||
                       (w_nzi > C_ZMAX) || (w_nzi < C_ZMIN);

  // State register; reset wins over any start or finish in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-cycle decision: limit, magnitude, overflow, commit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_finish    = 1'b0;
    w_esc_nxt   = 1'b0;
    w_ovf_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_iter == r_max) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_mag_esc) begin
          w_finish    = 1'b1;
          w_esc_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_range_ovf) begin
          w_finish    = 1'b1;
          w_esc_nxt   = 1'b1;
          w_ovf_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and iteration state; an overflowing z is never committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zr   <= '0;
      r_zi   <= '0;
      r_cr   <= '0;
      r_ci   <= '0;
      r_iter <= '0;
      r_max  <= '0;
    end else if (w_accept) begin
      r_zr   <= w_zr0;
      r_zi   <= w_zi0;
      r_cr   <= bus.in_cr;
      r_ci   <= bus.in_ci;
      r_max  <= bus.in_max_iter;
      r_iter <= '0;
    end else if (w_commit) begin
      r_zr   <= w_nzr[WIDTH-1:0];
      r_zi   <= w_nzi[WIDTH-1:0];
      r_iter <= r_iter + CTR_WIDTH'(1);
    end
  end

  // Result registers hold until the next finish; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_escaped  <= 1'b0;
      r_ovf      <= 1'b0;
      r_out_iter <= '0;
      r_out_zr   <= '0;
      r_out_zi   <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_escaped  <= w_esc_nxt;
        r_ovf      <= w_ovf_nxt;
        r_out_iter <= r_iter;
        r_out_zr   <= r_zr;
        r_out_zi   <= r_zi;
      end
    end
  end

  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = r_done;
  assign bus.out_iter    = r_out_iter;
  assign bus.out_escaped = r_escaped;
  assign bus.out_ovf     = r_ovf;
  assign bus.out_zr      = r_out_zr;
  assign bus.out_zi      = r_out_zi;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_iter_unit.sv
//==============================================================================
// Module      : tb_mandelbrot_iter_unit
// Description : Self-checking bench: directed cases plus randomized points
//               compared against an escape-time reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mandelbrot_iter_unit;
  localparam int W = 8;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mandelbrot_iter_unit_if #(.WIDTH(W), .CTR_WIDTH(CW)) bus ();

  mandelbrot_iter_unit #(.WIDTH(W), .CTR_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Escape-time reference: iterate the recurrence on plain integers.
  task automatic model(input logic [W-1:0] cr, ci, zr0, zi0, input bit julia,
                       input int mx, output int it, output bit esc, output bit ovf,
                       output logic [W-1:0] ozr, output logic [W-1:0] ozi);
    int zr, zi, nzr, nzi, c_r, c_i;
    zr = 0; zi = 0;
    c_r = int'($signed(cr));
    c_i = int'($signed(ci));
`ifdef MANDELBROT_JULIA_EN
    if (julia) begin
      zr = int'($signed(zr0));
      zi = int'($signed(zi0));
    end
`else
    if (julia) zr = zr + 0;
`endif
    it = 0; esc = 0; ovf = 0;
    while (1) begin
      if (it == mx) break;
      if (zr * zr + zi * zi > 4 * (1 << (2 * W - 4))) begin
        esc = 1;
        break;
      end
      nzr = ((zr * zr - zi * zi) >>> (W - 2)) + c_r;
      nzi = ((2 * zr * zi) >>> (W - 2)) + c_i;
      if (nzr < -(1 << (W - 1)) || nzr > (1 << (W - 1)) - 1 ||
          nzi < -(1 << (W - 1)) || nzi > (1 << (W - 1)) - 1) begin
        esc = 1;
        ovf = 1;
        break;
      end
      zr = nzr; zi = nzi; it++;
    end
    ozr = zr[W-1:0];
    ozi = zi[W-1:0];
  endtask

  // Present a request and let the DUT sample it at the next rising edge.
  task automatic issue(input string tag, input logic [W-1:0] cr, ci, zr0, zi0,
                       input bit julia, input int mx);
    bus.in_cr = cr; bus.in_ci = ci; bus.in_zr0 = zr0; bus.in_zi0 = zi0;
    bus.in_julia = julia; bus.in_max_iter = mx[CW-1:0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".busy_after_start"}, bus.busy, 1'b1);
  endtask

  // Wait for done (bounded), then check latency and the result fields.
  task automatic collect(input string tag, input int e_it, input bit e_esc, input bit e_ovf,
                         input logic [W-1:0] e_zr, input logic [W-1:0] e_zi, input int poke);
    int cyc;
    bit got;
    cyc = 0; got = 0;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        got = 1;
        break;
      end
      if (poke > 0 && cyc == poke) begin
        bus.start = 1'b1;
        bus.in_cr = W'($urandom);
        bus.in_max_iter = CW'($urandom);
      end else if (poke > 0 && cyc == poke + 1) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, got, 1'b1);
    check({tag, ".latency"}, cyc, e_it + 1);
    check({tag, ".busy_in_done"}, bus.busy, 1'b0);
    check({tag, ".iter"}, bus.out_iter, e_it);
    check({tag, ".escaped"}, bus.out_escaped, e_esc);
    check({tag, ".ovf"}, bus.out_ovf, e_ovf);
    check({tag, ".zr"}, bus.out_zr, e_zr);
    check({tag, ".zi"}, bus.out_zi, e_zi);
  endtask

  initial begin
    int          it;
    bit          esc, ovf, julia;
    logic [W-1:0] ezr, ezi, cr, ci, zr0, zi0;
    int          mx;

    bus.start = 0; bus.in_cr = 0; bus.in_ci = 0; bus.in_zr0 = 0; bus.in_zi0 = 0;
    bus.in_julia = 0; bus.in_max_iter = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.iter", bus.out_iter, 0);
    check("reset.flags", {bus.out_escaped, bus.out_ovf}, 0);
    check("reset.z", {bus.out_zr, bus.out_zi}, 0);
    @(negedge clk); rst = 0;

    // c = 0: runs to the limit.
    @(negedge clk);
    issue("c0", 8'h00, 8'h00, 8'h00, 8'h00, 0, 10);
    collect("c0", 10, 0, 0, 8'h00, 8'h00, 0);
    @(posedge clk); #1;
    check("c0.done_one_cycle", bus.done, 0);
    check("c0.hold_iter", bus.out_iter, 10);

    // c = 1.0: second step overflows; the overflowing z is not committed.
    @(negedge clk);
    issue("c1", 8'h40, 8'h00, 8'h00, 8'h00, 0, 50);
    collect("c1", 1, 1, 1, 8'h40, 8'h00, 0);

    // c = 1.5+1.5i: magnitude escape after one step.
    @(negedge clk);
    issue("c15", 8'h60, 8'h60, 8'h00, 8'h00, 0, 50);
    collect("c15", 1, 1, 0, 8'h60, 8'h60, 0);

    // c = -1.0 with a start pulse mid-run, then back-to-back from the done cycle.
    @(negedge clk);
    issue("cm1", 8'hC0, 8'h00, 8'h00, 8'h00, 0, 20);
    collect("cm1", 20, 0, 0, 8'h00, 8'h00, 3);
    issue("b2b", 8'h60, 8'h60, 8'h00, 8'h00, 0, 50);
    check("b2b.done_cleared", bus.done, 0);
    collect("b2b", 1, 1, 0, 8'h60, 8'h60, 0);

    // max_iter = 0 finishes immediately even for an escaping point.
    @(negedge clk);
    issue("mx0", 8'h60, 8'h60, 8'h00, 8'h00, 0, 0);
    collect("mx0", 0, 0, 0, 8'h00, 8'h00, 0);

    // Julia z0 = 1.5, c = 0.
    @(negedge clk);
    issue("julia", 8'h00, 8'h00, 8'h60, 8'h00, 1, 5);
`ifdef MANDELBROT_JULIA_EN
    collect("julia", 0, 1, 1, 8'h60, 8'h00, 0);
`else
    collect("julia", 5, 0, 0, 8'h00, 8'h00, 0);
`endif

    // Reset during the third RUN cycle aborts without done.
    @(negedge clk);
    issue("rst", 8'h00, 8'h00, 8'h00, 8'h00, 0, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst.done", bus.done, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.outs", {bus.out_iter, bus.out_escaped, bus.out_ovf, bus.out_zr, bus.out_zi}, 0);
    repeat (12) begin
      @(posedge clk); #1;
      check("rst.no_late_done", bus.done, 0);
    end
    @(negedge clk);
    issue("after_rst", 8'h40, 8'h00, 8'h00, 8'h00, 0, 50);
    collect("after_rst", 1, 1, 1, 8'h40, 8'h00, 0);

    // Randomized points against the reference model.
    for (int i = 0; i < 40; i++) begin
      cr = W'($urandom); ci = W'($urandom);
      zr0 = W'($urandom); zi0 = W'($urandom);
      julia = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) begin
        cr = W'($urandom_range(0, 31)) - 8'd16;
        ci = W'($urandom_range(0, 31)) - 8'd16;
        zr0 = 8'h00; zi0 = 8'h00;
      end
      mx = $urandom_range(0, 40);
      model(cr, ci, zr0, zi0, julia, mx, it, esc, ovf, ezr, ezi);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue("rand", cr, ci, zr0, zi0, julia, mx);
      collect("rand", it, esc, ovf, ezr, ezi, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
